// File: rtl/cam_req_sequencer.sv
// cam_req_sequencer: splits an in-order command stream into CAM update and
// lookup requests for cam_wrapper, tags lookups with an issue slot, keeps
// program order around updates and maps responses back to the caller's tag.
module cam_req_sequencer #(
    parameter int KEY_SIZE        = 8,
    parameter int VALUE_SIZE      = 32,
    parameter int TAG_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int UPDATE_SETTLE   = 8,
    localparam int SLOT_W         = $clog2(MAX_OUTSTANDING)
) (
    input  logic                  clk,
    input  logic                  rst,
    // command stream
    input  logic                  s_cmd_op,
    input  logic [KEY_SIZE-1:0]   s_cmd_key,
    input  logic [VALUE_SIZE-1:0] s_cmd_value,
    input  logic [TAG_WIDTH-1:0]  s_cmd_tag,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    // wrapper update channel
    output logic [KEY_SIZE-1:0]   update_req_index,
    output logic [VALUE_SIZE-1:0] update_req_data,
    output logic [TAG_WIDTH-1:0]  update_req_user,
    output logic                  update_req_valid,
    input  logic                  update_req_ready,
    // wrapper lookup request channel
    output logic [KEY_SIZE-1:0]   lookup_req_index,
    output logic [SLOT_W-1:0]     lookup_req_user,
    output logic                  lookup_req_valid,
    input  logic                  lookup_req_ready,
    // wrapper lookup value channel
    input  logic [VALUE_SIZE-1:0] lookup_value_data,
    input  logic [SLOT_W-1:0]     lookup_value_user,
    input  logic                  lookup_value_valid,
    output logic                  lookup_value_ready,
    // response stream
    output logic [VALUE_SIZE-1:0] m_rsp_data,
    output logic [TAG_WIDTH-1:0]  m_rsp_tag,
    output logic                  m_rsp_valid,
    input  logic                  m_rsp_ready,
    // status
    output logic [SLOT_W:0]       outstanding,
    output logic                  err_order
);

    localparam int SET_W = (UPDATE_SETTLE > 0) ? $clog2(UPDATE_SETTLE + 1) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(UPDATE_SETTLE);
    localparam logic [SLOT_W:0]   MAX_CNT     = (SLOT_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {ST_ISSUE, ST_DRAIN, ST_UPD, ST_SETTLE} state_t;

    state_t                r_state, w_next_state;
    logic [SLOT_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [SLOT_W:0]       r_outstanding;
    logic                  r_err_order;
    logic [SET_W-1:0]      r_settle_cnt;
    logic [KEY_SIZE-1:0]   r_hold_key;
    logic [VALUE_SIZE-1:0] r_hold_value;
    logic [TAG_WIDTH-1:0]  r_hold_tag;
    logic [TAG_WIDTH-1:0]  r_tag_table [MAX_OUTSTANDING];

    logic w_drained, w_slot_free;
    logic w_lkp_fire, w_upd_fire, w_rsp_fire, w_upd_accept;

    assign w_drained    = (r_outstanding == '0);
    assign w_slot_free  = (r_outstanding < MAX_CNT);
    assign w_lkp_fire   = lookup_req_valid && lookup_req_ready;
    assign w_upd_fire   = update_req_valid && update_req_ready;
    assign w_rsp_fire   = lookup_value_valid && lookup_value_ready;
    assign w_upd_accept = (r_state == ST_ISSUE) && s_cmd_valid && s_cmd_op;

    // Lookups pass straight through; updates are replayed from holding registers.
    assign lookup_req_index = s_cmd_key;
    assign lookup_req_user  = r_wr_ptr;
    assign update_req_index = r_hold_key;
    assign update_req_data  = r_hold_value;
    assign update_req_user  = r_hold_tag;

    // Response path is purely combinational; only the tag is remapped.
    assign m_rsp_valid        = lookup_value_valid;
    assign lookup_value_ready = m_rsp_ready;
    assign m_rsp_data         = lookup_value_data;
    assign m_rsp_tag          = r_tag_table[lookup_value_user];

    assign outstanding = r_outstanding;
    assign err_order   = r_err_order;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ISSUE;
        else     r_state <= w_next_state;
    end

    // Next-state: drain lookups before an update, then hold off lookups for the settle window.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ISSUE:  if (w_upd_accept) w_next_state = ST_DRAIN;
            ST_DRAIN:  if (w_drained) begin
                           if (w_upd_fire) w_next_state = (UPDATE_SETTLE > 0) ? ST_SETTLE : ST_ISSUE;
                           else            w_next_state = ST_UPD;
                       end
            ST_UPD:    if (w_upd_fire) w_next_state = (UPDATE_SETTLE > 0) ? ST_SETTLE : ST_ISSUE;
            ST_SETTLE: if (r_settle_cnt == SET_W'(1)) w_next_state = ST_ISSUE;
            default:   w_next_state = ST_ISSUE;
        endcase
    end

    // Outputs: DRAIN raises update_req_valid as soon as the registered count is zero.
    always_comb begin
        s_cmd_ready      = 1'b0;
        lookup_req_valid = 1'b0;
        update_req_valid = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                if (s_cmd_op) begin
                    s_cmd_ready = 1'b1;
                end else begin
                    lookup_req_valid = s_cmd_valid && w_slot_free;
                    s_cmd_ready      = lookup_req_valid && lookup_req_ready;
                end
            end
            ST_DRAIN: update_req_valid = w_drained;
            ST_UPD:   update_req_valid = 1'b1;
            default:  ;
        endcase
    end

    // Settle counter: loaded on the update handshake, counts down while in SETTLE.
    always_ff @(posedge clk) begin
        if (rst)                       r_settle_cnt <= '0;
        else if (w_upd_fire)           r_settle_cnt <= SETTLE_LOAD;
        else if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt - SET_W'(1);
    end

    // Capture the update command so the wrapper sees stable fields until ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_key   <= '0;
            r_hold_value <= '0;
            r_hold_tag   <= '0;
        end else if (w_upd_accept) begin
            r_hold_key   <= s_cmd_key;
            r_hold_value <= s_cmd_value;
            r_hold_tag   <= s_cmd_tag;
        end
    end

    // Slot pointers, in-flight count and sticky order error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_err_order   <= 1'b0;
        end else begin
            if (w_lkp_fire) r_wr_ptr <= r_wr_ptr + SLOT_W'(1);
            if (w_rsp_fire) begin
                r_rd_ptr <= r_rd_ptr + SLOT_W'(1);
                if ((lookup_value_user != r_rd_ptr) || w_drained) r_err_order <= 1'b1;
            end
            case ({w_lkp_fire, w_rsp_fire && !w_drained})
                2'b10:   r_outstanding <= r_outstanding + (SLOT_W + 1)'(1);
                2'b01:   r_outstanding <= r_outstanding - (SLOT_W + 1)'(1);
                default: ;
            endcase
        end
    end

    // Remember the caller tag for each issued slot.
    always_ff @(posedge clk) begin
        if (w_lkp_fire) r_tag_table[r_wr_ptr] <= s_cmd_tag;
    end

endmodule

// File: tb/tb_cam_req_sequencer.sv
// Directed testbench for cam_req_sequencer; the bench plays the wrapper.
module tb_cam_req_sequencer;

    localparam int KEY_SIZE = 8;
    localparam int VALUE_SIZE = 32;
    localparam int TAG_WIDTH = 4;
    localparam int MAX_OUTSTANDING = 8;
    localparam int UPDATE_SETTLE = 8;
    localparam int SLOT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_cmd_op, s_cmd_valid, s_cmd_ready;
    logic [KEY_SIZE-1:0] s_cmd_key;
    logic [VALUE_SIZE-1:0] s_cmd_value;
    logic [TAG_WIDTH-1:0] s_cmd_tag;
    logic [KEY_SIZE-1:0] update_req_index;
    logic [VALUE_SIZE-1:0] update_req_data;
    logic [TAG_WIDTH-1:0] update_req_user;
    logic update_req_valid, update_req_ready;
    logic [KEY_SIZE-1:0] lookup_req_index;
    logic [SLOT_W-1:0] lookup_req_user;
    logic lookup_req_valid, lookup_req_ready;
    logic [VALUE_SIZE-1:0] lookup_value_data;
    logic [SLOT_W-1:0] lookup_value_user;
    logic lookup_value_valid, lookup_value_ready;
    logic [VALUE_SIZE-1:0] m_rsp_data;
    logic [TAG_WIDTH-1:0] m_rsp_tag;
    logic m_rsp_valid, m_rsp_ready;
    logic [SLOT_W:0] outstanding;
    logic err_order;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cam_req_sequencer #(
        .KEY_SIZE(KEY_SIZE), .VALUE_SIZE(VALUE_SIZE), .TAG_WIDTH(TAG_WIDTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .UPDATE_SETTLE(UPDATE_SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .s_cmd_op(s_cmd_op), .s_cmd_key(s_cmd_key), .s_cmd_value(s_cmd_value),
        .s_cmd_tag(s_cmd_tag), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .update_req_index(update_req_index), .update_req_data(update_req_data),
        .update_req_user(update_req_user), .update_req_valid(update_req_valid),
        .update_req_ready(update_req_ready),
        .lookup_req_index(lookup_req_index), .lookup_req_user(lookup_req_user),
        .lookup_req_valid(lookup_req_valid), .lookup_req_ready(lookup_req_ready),
        .lookup_value_data(lookup_value_data), .lookup_value_user(lookup_value_user),
        .lookup_value_valid(lookup_value_valid), .lookup_value_ready(lookup_value_ready),
        .m_rsp_data(m_rsp_data), .m_rsp_tag(m_rsp_tag), .m_rsp_valid(m_rsp_valid),
        .m_rsp_ready(m_rsp_ready),
        .outstanding(outstanding), .err_order(err_order)
    );

    // Advance to 2 time units after the next rising edge.
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        s_cmd_valid = 1'b0; s_cmd_op = 1'b0; s_cmd_key = '0; s_cmd_value = '0; s_cmd_tag = '0;
        update_req_ready = 1'b1; lookup_req_ready = 1'b1;
        lookup_value_valid = 1'b0; lookup_value_data = '0; lookup_value_user = '0;
        m_rsp_ready = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic drive_lookup(input logic [7:0] key, input logic [3:0] tag);
        s_cmd_valid = 1'b1; s_cmd_op = 1'b0; s_cmd_key = key; s_cmd_tag = tag;
        #1;
    endtask

    task automatic drive_update(input logic [7:0] key, input logic [31:0] val, input logic [3:0] tag);
        s_cmd_valid = 1'b1; s_cmd_op = 1'b1; s_cmd_key = key; s_cmd_value = val; s_cmd_tag = tag;
        #1;
    endtask

    task automatic drive_rsp(input logic [2:0] user, input logic [31:0] data);
        lookup_value_valid = 1'b1; lookup_value_user = user; lookup_value_data = data;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        if (update_req_valid !== 1'b0) begin $display("FAIL rst_upd_valid: got %b want 0", update_req_valid); n_fail++; end
        n_checks++;
        if (lookup_req_valid !== 1'b0) begin $display("FAIL rst_lkp_valid: got %b want 0", lookup_req_valid); n_fail++; end
        n_checks++;
        if (m_rsp_valid !== 1'b0) begin $display("FAIL rst_rsp_valid: got %b want 0", m_rsp_valid); n_fail++; end
        n_checks++;
        if (outstanding !== 4'd0) begin $display("FAIL rst_outstanding: got %0d want 0", outstanding); n_fail++; end
        n_checks++;
        if (err_order !== 1'b0) begin $display("FAIL rst_err: got %b want 0", err_order); n_fail++; end
        n_checks++;
        rst = 1'b0;
        drive_lookup(8'h12, 4'd3);
        if (lookup_req_valid !== 1'b1 || lookup_req_index !== 8'h12 || lookup_req_user !== 3'd0 || s_cmd_ready !== 1'b1) begin
            $display("FAIL rst_first_lookup: got v=%b idx=%h user=%0d rdy=%b want v=1 idx=12 user=0 rdy=1",
                     lookup_req_valid, lookup_req_index, lookup_req_user, s_cmd_ready);
            n_fail++;
        end
        n_checks++;
        cyc();
        s_cmd_valid = 1'b0;
        #1;
        if (outstanding !== 4'd1) begin $display("FAIL rst_out_one: got %0d want 1", outstanding); n_fail++; end
        n_checks++;
        drive_rsp(3'd0, 32'hCAFE0001);
        if (m_rsp_valid !== 1'b1 || m_rsp_tag !== 4'd3 || m_rsp_data !== 32'hCAFE0001) begin
            $display("FAIL rst_rsp: got v=%b tag=%0d data=%h want v=1 tag=3 data=cafe0001", m_rsp_valid, m_rsp_tag, m_rsp_data);
            n_fail++;
        end
        n_checks++;
        cyc();
        lookup_value_valid = 1'b0;
        #1;
        if (outstanding !== 4'd0 || err_order !== 1'b0) begin
            $display("FAIL rst_final: got out=%0d err=%b want out=0 err=0", outstanding, err_order);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_round_trip;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_lookup(8'(8'h20 + i), 4'(i));
            if (s_cmd_ready !== 1'b1 || lookup_req_user !== 3'(i)) begin
                $display("FAIL rt_issue%0d: got rdy=%b user=%0d want rdy=1 user=%0d", i, s_cmd_ready, lookup_req_user, i);
                n_fail++;
            end
            n_checks++;
            cyc();
        end
        drive_lookup(8'h28, 4'd8);
        if (outstanding !== 4'd8 || s_cmd_ready !== 1'b0 || lookup_req_valid !== 1'b0) begin
            $display("FAIL rt_full: got out=%0d rdy=%b lv=%b want out=8 rdy=0 lv=0", outstanding, s_cmd_ready, lookup_req_valid);
            n_fail++;
        end
        n_checks++;
        s_cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_rsp(3'(i), 32'h1000 + i);
            if (m_rsp_valid !== 1'b1 || m_rsp_tag !== 4'(i) || m_rsp_data !== 32'(32'h1000 + i)) begin
                $display("FAIL rt_rsp%0d: got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h",
                         i, m_rsp_valid, m_rsp_tag, m_rsp_data, i, 32'h1000 + i);
                n_fail++;
            end
            n_checks++;
            cyc();
        end
        lookup_value_valid = 1'b0;
        #1;
        if (outstanding !== 4'd0 || err_order !== 1'b0) begin
            $display("FAIL rt_final: got out=%0d err=%b want out=0 err=0", outstanding, err_order);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_update_drain;
        do_reset();
        drive_lookup(8'h40, 4'd1);
        cyc();
        drive_lookup(8'h41, 4'd2);
        cyc();
        update_req_ready = 1'b0;
        drive_update(8'h05, 32'hDEADBEEF, 4'd9);
        if (s_cmd_ready !== 1'b1 || lookup_req_valid !== 1'b0) begin
            $display("FAIL ud_accept: got rdy=%b lv=%b want rdy=1 lv=0", s_cmd_ready, lookup_req_valid);
            n_fail++;
        end
        n_checks++;
        cyc();
        drive_lookup(8'h44, 4'd7);
        if (update_req_valid !== 1'b0 || s_cmd_ready !== 1'b0 || lookup_req_valid !== 1'b0) begin
            $display("FAIL ud_drain_hold: got uv=%b rdy=%b lv=%b want 0 0 0", update_req_valid, s_cmd_ready, lookup_req_valid);
            n_fail++;
        end
        n_checks++;
        drive_rsp(3'd0, 32'h0);
        if (m_rsp_tag !== 4'd1) begin $display("FAIL ud_rsp0_tag: got %0d want 1", m_rsp_tag); n_fail++; end
        n_checks++;
        cyc();
        drive_rsp(3'd1, 32'h1);
        if (update_req_valid !== 1'b0 || m_rsp_tag !== 4'd2) begin
            $display("FAIL ud_one_left: got uv=%b tag=%0d want uv=0 tag=2", update_req_valid, m_rsp_tag);
            n_fail++;
        end
        n_checks++;
        cyc();
        lookup_value_valid = 1'b0;
        #1;
        if (update_req_valid !== 1'b1 || update_req_index !== 8'h05 || update_req_data !== 32'hDEADBEEF || update_req_user !== 4'd9) begin
            $display("FAIL ud_req: got v=%b idx=%h data=%h user=%0d want v=1 idx=05 data=deadbeef user=9",
                     update_req_valid, update_req_index, update_req_data, update_req_user);
            n_fail++;
        end
        n_checks++;
        cyc();
        if (update_req_valid !== 1'b1 || update_req_index !== 8'h05 || update_req_data !== 32'hDEADBEEF || update_req_user !== 4'd9) begin
            $display("FAIL ud_req_stable: got v=%b idx=%h data=%h user=%0d want v=1 idx=05 data=deadbeef user=9",
                     update_req_valid, update_req_index, update_req_data, update_req_user);
            n_fail++;
        end
        n_checks++;
        update_req_ready = 1'b1;
        cyc();
        #1;
        if (update_req_valid !== 1'b0 || s_cmd_ready !== 1'b0) begin
            $display("FAIL ud_after_hs: got uv=%b rdy=%b want 0 0", update_req_valid, s_cmd_ready);
            n_fail++;
        end
        n_checks++;
        s_cmd_valid = 1'b0;
    endtask

    task automatic test_settle;
        do_reset();
        drive_update(8'h77, 32'h12345678, 4'hA);
        cyc();
        drive_lookup(8'h55, 4'hB);
        if (update_req_valid !== 1'b1 || update_req_index !== 8'h77 || update_req_user !== 4'hA) begin
            $display("FAIL st_upd_next_cycle: got v=%b idx=%h user=%h want v=1 idx=77 user=a",
                     update_req_valid, update_req_index, update_req_user);
            n_fail++;
        end
        n_checks++;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (lookup_req_valid !== 1'b0 || s_cmd_ready !== 1'b0) begin
                $display("FAIL st_blocked_M+%0d: got lv=%b rdy=%b want 0 0", k, lookup_req_valid, s_cmd_ready);
                n_fail++;
            end
            n_checks++;
            cyc();
        end
        #1;
        if (lookup_req_valid !== 1'b1 || lookup_req_index !== 8'h55 || lookup_req_user !== 3'd0 || s_cmd_ready !== 1'b1) begin
            $display("FAIL st_release_M+9: got lv=%b idx=%h user=%0d rdy=%b want 1 55 0 1",
                     lookup_req_valid, lookup_req_index, lookup_req_user, s_cmd_ready);
            n_fail++;
        end
        n_checks++;
        cyc();
        s_cmd_valid = 1'b0;
        #1;
        if (outstanding !== 4'd1) begin $display("FAIL st_out: got %0d want 1", outstanding); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back;
        logic [2:0] u;
        logic [3:0] t;
        do_reset();
        drive_lookup(8'h60, 4'd5);
        cyc();
        drive_lookup(8'h61, 4'd6);
        drive_rsp(3'd0, 32'h0);
        if (s_cmd_ready !== 1'b1 || lookup_req_user !== 3'd1 || m_rsp_tag !== 4'd5) begin
            $display("FAIL bb_same_cycle: got rdy=%b user=%0d tag=%0d want 1 1 5", s_cmd_ready, lookup_req_user, m_rsp_tag);
            n_fail++;
        end
        n_checks++;
        cyc();
        s_cmd_valid = 1'b0; lookup_value_valid = 1'b0;
        #1;
        if (outstanding !== 4'd1) begin $display("FAIL bb_out_unchanged: got %0d want 1", outstanding); n_fail++; end
        n_checks++;
        drive_rsp(3'd1, 32'h0);
        if (m_rsp_tag !== 4'd6) begin $display("FAIL bb_rsp1_tag: got %0d want 6", m_rsp_tag); n_fail++; end
        n_checks++;
        cyc();
        lookup_value_valid = 1'b0;
        // Slots 2..7 then wrap to 0,1 carrying tags 8..15.
        for (int i = 0; i < 8; i++) begin
            drive_lookup(8'(8'h80 + i), 4'(8 + i));
            if (s_cmd_ready !== 1'b1 || lookup_req_user !== 3'(i + 2)) begin
                $display("FAIL wrap_issue%0d: got rdy=%b user=%0d want rdy=1 user=%0d", i, s_cmd_ready, lookup_req_user, (i + 2) % 8);
                n_fail++;
            end
            n_checks++;
            cyc();
        end
        drive_lookup(8'h90, 4'd7);
        if (outstanding !== 4'd8 || s_cmd_ready !== 1'b0) begin
            $display("FAIL wrap_full: got out=%0d rdy=%b want 8 0", outstanding, s_cmd_ready);
            n_fail++;
        end
        n_checks++;
        drive_rsp(3'd2, 32'h0);
        if (m_rsp_tag !== 4'd8 || s_cmd_ready !== 1'b0) begin
            $display("FAIL wrap_free_cycle: got tag=%0d rdy=%b want 8 0", m_rsp_tag, s_cmd_ready);
            n_fail++;
        end
        n_checks++;
        cyc();
        lookup_value_valid = 1'b0;
        #1;
        if (s_cmd_ready !== 1'b1 || lookup_req_user !== 3'd2) begin
            $display("FAIL wrap_ready_rises: got rdy=%b user=%0d want 1 2", s_cmd_ready, lookup_req_user);
            n_fail++;
        end
        n_checks++;
        cyc();
        s_cmd_valid = 1'b0;
        m_rsp_ready = 1'b0;
        drive_rsp(3'd3, 32'hBEEF0003);
        for (int k = 0; k < 5; k++) begin
            if (lookup_value_ready !== 1'b0 || m_rsp_valid !== 1'b1 || m_rsp_tag !== 4'd9) begin
                $display("FAIL bp_hold%0d: got lvr=%b v=%b tag=%0d want 0 1 9", k, lookup_value_ready, m_rsp_valid, m_rsp_tag);
                n_fail++;
            end
            n_checks++;
            cyc();
            #1;
        end
        if (outstanding !== 4'd8) begin $display("FAIL bp_out: got %0d want 8", outstanding); n_fail++; end
        n_checks++;
        m_rsp_ready = 1'b1;
        #1;
        if (lookup_value_ready !== 1'b1 || m_rsp_data !== 32'hBEEF0003 || m_rsp_tag !== 4'd9) begin
            $display("FAIL bp_release: got lvr=%b data=%h tag=%0d want 1 beef0003 9", lookup_value_ready, m_rsp_data, m_rsp_tag);
            n_fail++;
        end
        n_checks++;
        cyc();
        for (int j = 0; j < 7; j++) begin
            u = 3'(4 + j);
            t = (j < 6) ? 4'(10 + j) : 4'd7;
            drive_rsp(u, 32'h0);
            if (m_rsp_tag !== t) begin $display("FAIL wrap_rsp%0d: got tag=%0d want %0d", u, m_rsp_tag, t); n_fail++; end
            n_checks++;
            cyc();
        end
        lookup_value_valid = 1'b0;
        #1;
        if (outstanding !== 4'd0 || err_order !== 1'b0) begin
            $display("FAIL bb_final: got out=%0d err=%b want 0 0", outstanding, err_order);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_order_error;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_lookup(8'(8'hA0 + i), 4'(i + 1));
            cyc();
        end
        s_cmd_valid = 1'b0;
        drive_rsp(3'd2, 32'h0);
        if (err_order !== 1'b0 || m_rsp_tag !== 4'd3) begin
            $display("FAIL oe_before: got err=%b tag=%0d want 0 3", err_order, m_rsp_tag);
            n_fail++;
        end
        n_checks++;
        cyc();
        lookup_value_valid = 1'b0;
        #1;
        if (err_order !== 1'b1) begin $display("FAIL oe_set: got %b want 1", err_order); n_fail++; end
        n_checks++;
        cyc();
        cyc();
        cyc();
        if (err_order !== 1'b1) begin $display("FAIL oe_sticky: got %b want 1", err_order); n_fail++; end
        n_checks++;
        do_reset();
        if (err_order !== 1'b0 || outstanding !== 4'd0) begin
            $display("FAIL oe_reset_clears: got err=%b out=%0d want 0 0", err_order, outstanding);
            n_fail++;
        end
        n_checks++;
        drive_rsp(3'd0, 32'h0);
        cyc();
        lookup_value_valid = 1'b0;
        #1;
        if (err_order !== 1'b1 || outstanding !== 4'd0) begin
            $display("FAIL oe_stray_rsp: got err=%b out=%0d want 1 0", err_order, outstanding);
            n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_trip();
        test_update_drain();
        test_settle();
        test_back_to_back();
        test_order_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
